// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input and register-write/status outputs of the UART command sequencer.
// The controller uses the master modport; its environment uses the slave modport.
interface uart_cmd_ctrl_if;
  logic        i_rx_byte_rdy;
  logic [7:0]  i_rx_byte;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic        o_err_cksum;
  logic        o_err_timeout;
  logic [7:0]  o_err_count;
  logic [7:0]  o_pkt_count;

  modport master (
    input  i_rx_byte_rdy, i_rx_byte,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy,
    output o_err_cksum, o_err_timeout, o_err_count, o_pkt_count
  );

  modport slave (
    output i_rx_byte_rdy, i_rx_byte,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy,
    input  o_err_cksum, o_err_timeout, o_err_count, o_pkt_count
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frames 5-byte write packets (sync, addr, hi, lo, checksum) from the uart_rx byte stream
// and issues them as single-cycle register writes. Bad checksums and inter-byte timeouts are flagged.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input logic            i_clk,
  input logic            i_rst,
  uart_cmd_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CKSUM} state_t;

  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CLKS - 1);

  state_t      state, state_next;
  logic [19:0] gap_cnt, gap_cnt_next;
  logic [7:0]  addr_q, addr_next;
  logic [7:0]  hi_q, hi_next;
  logic [7:0]  lo_q, lo_next;
  logic [7:0]  sum;

  logic        wr_en_q, wr_en_next;
  logic [7:0]  wr_addr_q, wr_addr_next;
  logic [15:0] wr_data_q, wr_data_next;
  logic        busy_q, busy_next;
  logic        err_cksum_q, err_cksum_next;
  logic        err_timeout_q, err_timeout_next;
  logic [7:0]  err_count_q, err_count_next;
  logic [7:0]  pkt_count_q, pkt_count_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      addr_q        <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      err_cksum_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
      pkt_count_q   <= '0;
    end else begin
      state         <= state_next;
      gap_cnt       <= gap_cnt_next;
      addr_q        <= addr_next;
      hi_q          <= hi_next;
      lo_q          <= lo_next;
      wr_en_q       <= wr_en_next;
      wr_addr_q     <= wr_addr_next;
      wr_data_q     <= wr_data_next;
      busy_q        <= busy_next;
      err_cksum_q   <= err_cksum_next;
      err_timeout_q <= err_timeout_next;
      err_count_q   <= err_count_next;
      pkt_count_q   <= pkt_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    gap_cnt_next     = gap_cnt;
    addr_next        = addr_q;
    hi_next          = hi_q;
    lo_next          = lo_q;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_q;
    wr_data_next     = wr_data_q;
    err_cksum_next   = 1'b0;
    err_timeout_next = 1'b0;
    err_count_next   = err_count_q;
    pkt_count_next   = pkt_count_q;
    sum              = addr_q + hi_q + lo_q + bus.i_rx_byte;

    case (state)
      IDLE: begin
        gap_cnt_next = '0;
        if (bus.i_rx_byte_rdy && bus.i_rx_byte == SYNC_BYTE) begin
          state_next = ADDR;
        end
      end
      default: begin
        // A strobe always wins over a timeout landing in the same cycle.
        if (bus.i_rx_byte_rdy) begin
          gap_cnt_next = '0;
          case (state)
            ADDR: begin
              addr_next  = bus.i_rx_byte;
              state_next = DHI;
            end
            DHI: begin
              hi_next    = bus.i_rx_byte;
              state_next = DLO;
            end
            DLO: begin
              lo_next    = bus.i_rx_byte;
              state_next = CKSUM;
            end
            default: begin
              state_next = IDLE;
              if (sum == 8'h00) begin
                wr_en_next   = 1'b1;
                wr_addr_next = addr_q;
                wr_data_next = {hi_q, lo_q};
              end else begin
                err_cksum_next = 1'b1;
              end
            end
          endcase
        end else if (gap_cnt == TIMEOUT_LAST) begin
          err_timeout_next = 1'b1;
          state_next       = IDLE;
          gap_cnt_next     = '0;
        end else begin
          gap_cnt_next = gap_cnt + 20'd1;
        end
      end
    endcase

    if ((err_cksum_next || err_timeout_next) && err_count_q != 8'hFF) begin
      err_count_next = err_count_q + 8'd1;
    end
    if (wr_en_next) begin
      pkt_count_next = pkt_count_q + 8'd1;
    end
    busy_next = (state_next != IDLE);
  end

  assign bus.o_wr_en       = wr_en_q;
  assign bus.o_wr_addr     = wr_addr_q;
  assign bus.o_wr_data     = wr_data_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_err_cksum   = err_cksum_q;
  assign bus.o_err_timeout = err_timeout_q;
  assign bus.o_err_count   = err_count_q;
  assign bus.o_pkt_count   = pkt_count_q;

endmodule
